wb_memwide_bridge: RTL and testbench
====================================

// Module: wb_memwide_bridge
// PURPOSE
// Wishbone 32-bit slave giving access to a control/status register pair and to an
// external synchronous SRAM of MEM_DW bits (MEM_DW/32 lanes) with read-modify-free
// coherent wide access. It is the parametrised successor of the fixed 32-bit read-only
// memory interface: it supports wide reads via snapshot, wide writes via a staging
// buffer, a configurable SRAM read latency, and an error response.
// PARAMETERS
// MEM_DW  64  SRAM word width; multiple of 32, power of 2 (LANES = MEM_DW/32, >=2)
// MEM_AW  5   SRAM word-address width (depth 2**MEM_AW)
// RD_LAT  1   cycles from mem_rd_o pulse to valid mem_data_i; 1..7
// ADR_W (localparam) = MEM_AW + log2(LANES) + 3; bit ADR_W-1 = 1 selects memory
// PORTS
// clk_i          in   1          clock
// rst_i          in   1          synchronous reset, active-high
// wb_cyc_i       in   1          WB cycle
// wb_stb_i       in   1          WB strobe
// wb_adr_i       in   ADR_W-2    WB word address [ADR_W-1:2]
// wb_sel_i       in   4          WB byte selects
// wb_we_i        in   1          WB write enable
// wb_dat_i       in   32         WB write data
// wb_ack_o       out  1          WB ack, one-cycle pulse
// wb_err_o       out  1          WB error, one-cycle pulse
// wb_rty_o       out  1          tied 0
// wb_stall_o     out  1          ~(ack|err) & cyc & stb
// wb_dat_o       out  32         WB read data, valid with ack
// ctrl_field0_o  out  1          CTRL bit0
// mem_addr_o     out  MEM_AW     SRAM word address
// mem_rd_o       out  1          SRAM read strobe, one cycle
// mem_data_i     in   MEM_DW     SRAM read data
// mem_wr_o       out  1          SRAM write strobe, one cycle
// mem_data_o     out  MEM_DW     SRAM write data
// mem_be_o       out  MEM_DW/8   SRAM byte enables
// BEHAVIOUR
// - Reset: every output 0; FSM IDLE; CTRL=0; stage, snapshot and sticky flags cleared.
// - Register map (adr MSB=0): 0x00 CTRL: bit0 field0 RW; bit31 W1 clears stage+snapshot,
//   reads 0. 0x04 STATUS: bit0 stage_pending, bit1 snap_valid, bit2 discard sticky (W1C).
//   Any other register offset -> wb_err_o, no state change, wr data ignored.
// - Memory address: index = adr[ADR_W-2:log2(LANES)+2], lane = adr[log2(LANES)+1:2].
// - One transaction in flight; request accepted in IDLE when cyc&stb (cycle 0).
// - Reg access, stage write, snapshot hit: ack/err at cycle 1.
// - Memory read, lane 0 or snapshot miss (invalid or index differs): mem_rd_o+mem_addr_o
//   at cycle 1; mem_data_i captured into snapshot at cycle 1+RD_LAT; ack at cycle 2+RD_LAT
//   with the requested lane. Lane 0 always refetches (coherent snapshot start).
// - Memory read, lane>0 and snapshot valid with same index: no SRAM access, ack cycle 1.
// - Memory write, lane<LANES-1: bytes merged into stage per wb_sel_i, stage_be ORed; if
//   stage pending with a different index, old stage discarded first, discard flag set.
// - Memory write, lane LANES-1: mem_wr_o at cycle 1 with stage+top bytes, mem_be_o =
//   stage_be|top sel (stage part only if same index, else discarded+flag); ack cycle 2;
//   stage cleared; snapshot invalidated if its index equals written index.
// - wb_sel_i=0 on top-lane write: still commits stage bytes; on other writes: no effect.
// - FSM: IDLE -> RD_WAIT (RD_LAT-counter) -> ACK; IDLE -> WR_COMMIT -> ACK; IDLE -> ACK.
// - cyc dropped mid-transaction: internal actions complete, ack/err suppressed.
// - Reset mid-transaction: immediate return to IDLE; no strobe/ack emitted afterwards.
// STRUCTURE
// - Package memwide_pkg: register offsets, CTRL/STATUS bit indices, FSM state enum,
//   lane-count/log2 helper functions.
// - Sub-module memwide_lane_merge: combinational byte-enable merge of a 32-bit lane into
//   an MEM_DW word and its byte-enable vector; used for stage update and commit.
// TESTING
// - Reset then read 0x00,0x04 -> ack at cycle 1, data 0; all mem strobes 0.
// - MEM_DW=64, RD_LAT=3: SRAM[2]=0x1111_2222_3333_4444; read lane0 idx2 -> mem_rd_o cycle 1,
//   ack cycle 5, dat 0x3333_4444; read lane1 -> ack cycle 1, dat 0x1111_2222, no mem_rd_o.
// - Write lane0 idx4 0xAABBCCDD sel 0xF, lane1 idx4 0x01020304 sel 0x3 -> one mem_wr_o,
//   addr 4, data[47:0]=0x0304_AABBCCDD, be 0x3F; STATUS bit0 back to 0.
// - Write lane0 idx1 then lane0 idx3 -> STATUS=0x5; write 0x04 with 0x4 -> STATUS=0x1.
// - Read offset 0x08 -> wb_err_o one cycle at cycle 1, no ack; CTRL unchanged.
// - Assert rst_i during RD_WAIT -> no ack, mem_rd_o 0, STATUS=0 next cycle.

Source files
------------

// File: rtl/memwide_pkg.sv
// Shared constants for the wide-memory Wishbone bridge: register map, bit
// positions, FSM state codes and lane-geometry helpers.
package memwide_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;

  localparam int CTRL_FIELD0 = 0;
  localparam int CTRL_CLR    = 31;

  localparam int ST_PEND = 0;
  localparam int ST_SNAP = 1;
  localparam int ST_DISC = 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RD_WAIT   = 2'd1;
  localparam logic [1:0] S_WR_COMMIT = 2'd2;
  localparam logic [1:0] S_ACK       = 2'd3;

  function automatic int lanes_f(input int dw);
    return dw / 32;
  endfunction

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/memwide_lane_merge.sv
// Byte-enable merge of one 32-bit lane into a wide SRAM word and its
// byte-enable vector. Bytes outside the selected lane pass through.
module memwide_lane_merge
  import memwide_pkg::*;
#(
  parameter  int MEM_DW = 64,
  localparam int LB     = log2_f(lanes_f(MEM_DW)),
  localparam int NB     = MEM_DW / 8
)(
  input  logic [MEM_DW-1:0] word_i,
  input  logic [NB-1:0]     be_i,
  input  logic [LB-1:0]     lane_i,
  input  logic [31:0]       dat_i,
  input  logic [3:0]        sel_i,
  output logic [MEM_DW-1:0] word_o,
  output logic [NB-1:0]     be_o
);
  for (genvar b = 0; b < NB; b++) begin : g_byte
    localparam logic [LB-1:0] BL = LB'(b / 4);
    logic hit;
    assign hit              = (lane_i == BL) && sel_i[b % 4];
    assign word_o[b*8 +: 8] = hit ? dat_i[(b % 4)*8 +: 8] : word_i[b*8 +: 8];
    assign be_o[b]          = be_i[b] | hit;
  end
endmodule

// File: rtl/wb_memwide_bridge.sv
// Wishbone 32-bit slave in front of a wide synchronous SRAM. Wide reads are
// served from a snapshot refilled on lane 0 (or on a miss); wide writes are
// collected in a staging buffer and committed when the top lane is written.
module wb_memwide_bridge
  import memwide_pkg::*;
#(
  parameter  int MEM_DW = 64,
  parameter  int MEM_AW = 5,
  parameter  int RD_LAT = 1,
  localparam int LANES  = lanes_f(MEM_DW),
  localparam int LB     = log2_f(LANES),
  localparam int NB     = MEM_DW / 8,
  localparam int ADR_W  = MEM_AW + LB + 3
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [ADR_W-1:2]  wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              wb_stall_o,
  output logic [31:0]       wb_dat_o,
  output logic              ctrl_field0_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [MEM_DW-1:0] mem_data_i,
  output logic              mem_wr_o,
  output logic [MEM_DW-1:0] mem_data_o,
  output logic [NB-1:0]     mem_be_o
);
  localparam logic [ADR_W-2:0] OFF_CTRL   = (ADR_W-1)'(REG_CTRL);
  localparam logic [ADR_W-2:0] OFF_STATUS = (ADR_W-1)'(REG_STATUS);
  localparam logic [LB-1:0]    LANE_TOP   = '1;
  localparam logic [2:0]       RD_CNT     = 3'(RD_LAT);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [31:0]       dat_q, dat_d;
  logic              ctrl0_q, ctrl0_d;
  logic              disc_q, disc_d;
  logic [MEM_DW-1:0] stage_q, stage_d;
  logic [NB-1:0]     stage_be_q, stage_be_d;
  logic [MEM_AW-1:0] stage_idx_q, stage_idx_d;
  logic              stage_pend_q, stage_pend_d;
  logic [MEM_DW-1:0] snap_q, snap_d;
  logic [MEM_AW-1:0] snap_idx_q, snap_idx_d;
  logic              snap_vld_q, snap_vld_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [MEM_DW-1:0] mem_dat_q, mem_dat_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;

  // Request decode fields
  logic              is_mem;
  logic [MEM_AW-1:0] idx;
  logic [LB-1:0]     lane;
  logic [ADR_W-2:0]  reg_off;
  assign is_mem  = wb_adr_i[ADR_W-1];
  assign idx     = wb_adr_i[ADR_W-2:LB+2];
  assign lane    = wb_adr_i[LB+1:2];
  assign reg_off = {wb_adr_i[ADR_W-2:2], 2'b00};

  // A pending stage for another index is dropped before the new bytes land
  logic              stage_diff, snap_hit;
  logic [MEM_DW-1:0] mrg_base, mrg_word;
  logic [NB-1:0]     mrg_base_be, mrg_be;
  assign stage_diff  = stage_pend_q && (stage_idx_q != idx);
  assign snap_hit    = (lane != '0) && snap_vld_q && (snap_idx_q == idx);
  assign mrg_base    = stage_diff ? '0 : stage_q;
  assign mrg_base_be = stage_diff ? '0 : stage_be_q;

  memwide_lane_merge #(.MEM_DW(MEM_DW)) u_merge (
    .word_i (mrg_base),
    .be_i   (mrg_base_be),
    .lane_i (lane),
    .dat_i  (wb_dat_i),
    .sel_i  (wb_sel_i),
    .word_o (mrg_word),
    .be_o   (mrg_be)
  );

  // Register read values
  logic [31:0] ctrl_rd, status_rd;
  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_FIELD0] = ctrl0_q;
    status_rd            = '0;
    status_rd[ST_PEND]   = stage_pend_q;
    status_rd[ST_SNAP]   = snap_vld_q;
    status_rd[ST_DISC]   = disc_q;
  end

  // Next state: decode in IDLE, read-latency countdown, commit and ack sequencing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    lane_d       = lane_q;
    dat_d        = dat_q;
    ctrl0_d      = ctrl0_q;
    disc_d       = disc_q;
    stage_d      = stage_q;
    stage_be_d   = stage_be_q;
    stage_idx_d  = stage_idx_q;
    stage_pend_d = stage_pend_q;
    snap_d       = snap_q;
    snap_idx_d   = snap_idx_q;
    snap_vld_d   = snap_vld_q;
    mem_addr_d   = mem_addr_q;
    mem_dat_d    = mem_dat_q;
    mem_be_d     = mem_be_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    case (state_q)
      S_IDLE: if (wb_cyc_i && wb_stb_i) begin
        state_d = S_ACK;
        err_d   = 1'b0;
        if (!is_mem) begin
          if (reg_off == OFF_CTRL) begin
            dat_d = ctrl_rd;
            if (wb_we_i) begin
              if (wb_sel_i[CTRL_FIELD0/8]) ctrl0_d = wb_dat_i[CTRL_FIELD0];
              if (wb_sel_i[CTRL_CLR/8] && wb_dat_i[CTRL_CLR]) begin
                stage_d      = '0;
                stage_be_d   = '0;
                stage_pend_d = 1'b0;
                snap_vld_d   = 1'b0;
              end
            end
          end else if (reg_off == OFF_STATUS) begin
            dat_d = status_rd;
            if (wb_we_i && wb_sel_i[ST_DISC/8] && wb_dat_i[ST_DISC]) disc_d = 1'b0;
          end else begin
            err_d = 1'b1;
            dat_d = '0;
          end
        end else if (!wb_we_i) begin
          if (snap_hit) begin
            dat_d = snap_q[{lane, 5'd0} +: 32];
          end else begin
            mem_rd_d   = 1'b1;
            mem_addr_d = idx;
            lane_d     = lane;
            cnt_d      = RD_CNT;
            state_d    = S_RD_WAIT;
          end
        end else if (lane != LANE_TOP) begin
          if (wb_sel_i != 4'b0) begin
            stage_d      = mrg_word;
            stage_be_d   = mrg_be;
            stage_idx_d  = idx;
            stage_pend_d = 1'b1;
            if (stage_diff) disc_d = 1'b1;
          end
        end else begin
          mem_wr_d     = 1'b1;
          mem_addr_d   = idx;
          mem_dat_d    = mrg_word;
          mem_be_d     = mrg_be;
          if (stage_diff) disc_d = 1'b1;
          stage_d      = '0;
          stage_be_d   = '0;
          stage_pend_d = 1'b0;
          if (snap_vld_q && (snap_idx_q == idx)) snap_vld_d = 1'b0;
          state_d      = S_WR_COMMIT;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          snap_d     = mem_data_i;
          snap_idx_d = mem_addr_q;
          snap_vld_d = 1'b1;
          dat_d      = mem_data_i[{lane_q, 5'd0} +: 32];
          state_d    = S_ACK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WR_COMMIT: state_d = S_ACK;
      default:     state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      lane_q       <= '0;
      dat_q        <= '0;
      ctrl0_q      <= 1'b0;
      disc_q       <= 1'b0;
      stage_q      <= '0;
      stage_be_q   <= '0;
      stage_idx_q  <= '0;
      stage_pend_q <= 1'b0;
      snap_q       <= '0;
      snap_idx_q   <= '0;
      snap_vld_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_dat_q    <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      lane_q       <= lane_d;
      dat_q        <= dat_d;
      ctrl0_q      <= ctrl0_d;
      disc_q       <= disc_d;
      stage_q      <= stage_d;
      stage_be_q   <= stage_be_d;
      stage_idx_q  <= stage_idx_d;
      stage_pend_q <= stage_pend_d;
      snap_q       <= snap_d;
      snap_idx_q   <= snap_idx_d;
      snap_vld_q   <= snap_vld_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_dat_q    <= mem_dat_d;
      mem_be_q     <= mem_be_d;
    end
  end

  // Ack/err are only shown while the master still holds the cycle
  assign wb_ack_o      = (state_q == S_ACK) && !err_q && wb_cyc_i;
  assign wb_err_o      = (state_q == S_ACK) &&  err_q && wb_cyc_i;
  assign wb_rty_o      = 1'b0;
  assign wb_stall_o    = !(wb_ack_o || wb_err_o) && wb_cyc_i && wb_stb_i;
  assign wb_dat_o      = dat_q;
  assign ctrl_field0_o = ctrl0_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_rd_o      = mem_rd_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_data_o    = mem_dat_q;
  assign mem_be_o      = mem_be_q;
endmodule

// File: tb/tb_wb_memwide_bridge.sv
// Bench for wb_memwide_bridge (64-bit SRAM, read latency 3): directed table,
// multi-cycle corner sequences, then random traffic against a reference model.
module tb_wb_memwide_bridge;
  localparam int MEM_DW = 64;
  localparam int MEM_AW = 5;
  localparam int RD_LAT = 3;
  localparam int NB     = MEM_DW / 8;
  localparam int MISS   = 2 + RD_LAT;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [8:2] wb_adr_i = '0;
  logic [3:0] wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, ctrl_field0_o;
  logic [31:0] wb_dat_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic mem_rd_o, mem_wr_o;
  logic [MEM_DW-1:0] mem_data_i, mem_data_o;
  logic [NB-1:0] mem_be_o;

  always #5 clk_i = ~clk_i;

  wb_memwide_bridge #(.MEM_DW(MEM_DW), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_stall_o(wb_stall_o),
    .wb_dat_o(wb_dat_o), .ctrl_field0_o(ctrl_field0_o), .mem_addr_o(mem_addr_o),
    .mem_rd_o(mem_rd_o), .mem_data_i(mem_data_i), .mem_wr_o(mem_wr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o)
  );

  // SRAM: data for a read strobe appears exactly RD_LAT cycles later, junk otherwise
  typedef struct packed { logic v; logic [MEM_AW-1:0] a; } rdp_t;
  rdp_t rd_pipe [RD_LAT];
  logic [MEM_DW-1:0] sram [32];
  logic pre_en = 1'b0;
  logic [MEM_AW-1:0] pre_a = '0;
  logic [MEM_DW-1:0] pre_d = '0;
  logic [MEM_AW-1:0] last_wr_a;
  logic [NB-1:0] last_wr_be;

  assign mem_data_i = rd_pipe[RD_LAT-1].v ? sram[rd_pipe[RD_LAT-1].a] : 64'hDEAD_BEEF_5A5A_A5A5;

  // SRAM behaviour: read pipeline, byte-enabled writes, bench preloads
  always @(posedge clk_i) begin
    rd_pipe[0] <= rst_i ? '0 : {mem_rd_o, mem_addr_o};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (pre_en) sram[pre_a] <= pre_d;
    else if (mem_wr_o) begin
      last_wr_a  <= mem_addr_o;
      last_wr_be <= mem_be_o;
      for (int b = 0; b < NB; b++)
        if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sram_load(input int a, input logic [63:0] d);
    pre_en = 1'b1; pre_a = MEM_AW'(a); pre_d = d;
    @(posedge clk_i); #1;
    pre_en = 1'b0;
  endtask

  function automatic logic [6:0] ra(input int off);
    return 7'(off >> 2);
  endfunction

  function automatic logic [6:0] ma(input int idx, input int lane);
    return {1'b1, 5'(idx), 1'(lane)};
  endfunction

  // One bus transaction, started in an idle cycle; returns cycle numbers relative to cycle 0
  task automatic xfer(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdat, output logic err,
                      output int lat, output int rd_cyc, output int wr_cyc);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    lat = -1; rd_cyc = -1; wr_cyc = -1; err = 1'b0; rdat = '0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk_i); #1;
      if (mem_rd_o && rd_cyc < 0) rd_cyc = k;
      if (mem_wr_o && wr_cyc < 0) wr_cyc = k;
      if (wb_ack_o || wb_err_o) begin
        lat = k; err = wb_err_o; rdat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_i); #1;
    if (lat > 0) chk("ack pulse width", {wb_ack_o, wb_err_o}, 2'b00);
  endtask

  task automatic run(input string nm, input logic we, input logic [6:0] adr,
                     input logic [3:0] sel, input logic [31:0] dat, input logic cdat,
                     input logic [31:0] edat, input logic eerr, input int elat,
                     input int erd, input int ewr);
    logic [31:0] rd; logic er; int lt, rc, wc;
    xfer(we, adr, sel, dat, rd, er, lt, rc, wc);
    chk({nm, " lat"}, lt, elat);
    chk({nm, " err"}, er, eerr);
    chk({nm, " mem_rd cycle"}, rc, erd);
    chk({nm, " mem_wr cycle"}, wc, ewr);
    if (cdat) chk({nm, " dat"}, rd, edat);
  endtask

  typedef struct {
    logic we; logic [6:0] adr; logic [3:0] sel; logic [31:0] dat;
    logic cdat; logic [31:0] edat; logic eerr; int elat; int erd; int ewr;
  } vec_t;
  vec_t tv [24];
  int nv = 0;

  task automatic add(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic cdat, input logic [31:0] edat,
                     input logic eerr, input int elat, input int erd, input int ewr);
    tv[nv] = '{we, adr, sel, dat, cdat, edat, eerr, elat, erd, ewr};
    nv++;
  endtask

  // Reference model state
  logic [63:0] exp_mem [8];
  logic m_ctrl0, m_snap_v, m_pend, m_disc;
  int m_snap_idx, m_st_idx;
  logic [7:0] m_st_b [NB];
  logic [NB-1:0] m_st_be;

  initial begin
    logic acc;
    logic [31:0] rd; logic er; int lt, rc, wc;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    sram_load(2, 64'h1111_2222_3333_4444);
    sram_load(4, 64'h0);
    chk("reset wb outputs", {wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o, ctrl_field0_o}, '0);
    chk("reset mem outputs", {mem_addr_o, mem_rd_o, mem_wr_o, mem_data_o, mem_be_o}, '0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed table
    add(0, ra(0),  4'hF, 0,            1, 32'h0,         0, 1,    -1, -1);
    add(0, ra(4),  4'hF, 0,            1, 32'h0,         0, 1,    -1, -1);
    add(0, ma(2,0),4'hF, 0,            1, 32'h3333_4444, 0, MISS,  1, -1);
    add(0, ma(2,1),4'hF, 0,            1, 32'h1111_2222, 0, 1,    -1, -1);
    add(1, ma(4,0),4'hF, 32'hAABBCCDD, 0, 0,             0, 1,    -1, -1);
    add(0, ra(4),  4'hF, 0,            1, 32'h3,         0, 1,    -1, -1);
    add(1, ma(4,1),4'h3, 32'h01020304, 0, 0,             0, 2,    -1,  1);
    add(0, ra(4),  4'hF, 0,            1, 32'h2,         0, 1,    -1, -1);
    add(1, ra(0),  4'hF, 32'h8000_0001,0, 0,             0, 1,    -1, -1);
    add(0, ra(4),  4'hF, 0,            1, 32'h0,         0, 1,    -1, -1);
    add(0, ra(0),  4'hF, 0,            1, 32'h1,         0, 1,    -1, -1);
    add(1, ma(1,0),4'hF, 32'h11,       0, 0,             0, 1,    -1, -1);
    add(1, ma(3,0),4'hF, 32'h22,       0, 0,             0, 1,    -1, -1);
    add(0, ra(4),  4'hF, 0,            1, 32'h5,         0, 1,    -1, -1);
    add(1, ra(4),  4'hF, 32'h4,        0, 0,             0, 1,    -1, -1);
    add(0, ra(4),  4'hF, 0,            1, 32'h1,         0, 1,    -1, -1);
    add(0, ra(8),  4'hF, 0,            0, 0,             1, 1,    -1, -1);
    add(1, ra(12), 4'hF, 32'h0,        0, 0,             1, 1,    -1, -1);
    add(0, ra(0),  4'hF, 0,            1, 32'h1,         0, 1,    -1, -1);
    for (int i = 0; i < nv; i++)
      run($sformatf("t%0d", i), tv[i].we, tv[i].adr, tv[i].sel, tv[i].dat, tv[i].cdat,
          tv[i].edat, tv[i].eerr, tv[i].elat, tv[i].erd, tv[i].ewr);
    chk("commit sram[4]", sram[4], 64'h0000_0304_AABB_CCDD);
    chk("commit be", last_wr_be, 8'h3F);
    chk("commit addr", last_wr_a, 5'd4);
    chk("ctrl_field0_o", ctrl_field0_o, 1'b1);

    // cyc dropped during a miss: snapshot still fills, no ack shown
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ma(2,0); wb_sel_i = 4'hF;
    @(posedge clk_i); #1;
    chk("drop mem_rd", mem_rd_o, 1'b1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acc = 1'b0;
    repeat (8) begin @(posedge clk_i); #1; acc |= wb_ack_o | wb_err_o; end
    chk("drop no ack", acc, 1'b0);
    run("drop hit", 0, ma(2,1), 4'hF, 0, 1, 32'h1111_2222, 0, 1, -1, -1);

    // reset during RD_WAIT
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ma(5,0);
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst mem_rd", mem_rd_o, 1'b0);
    acc = 1'b0;
    repeat (8) begin acc |= wb_ack_o | wb_err_o | mem_rd_o; @(posedge clk_i); #1; end
    chk("rst no ack/strobe", acc, 1'b0);
    wb_cyc_i = 1'b0;
    @(posedge clk_i); #1;
    run("rst status", 0, ra(4), 4'hF, 0, 1, 32'h0, 0, 1, -1, -1);
    chk("rst ctrl_field0_o", ctrl_field0_o, 1'b0);

    // Random traffic against the reference model
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = {$urandom, $urandom};
      sram_load(i, exp_mem[i]);
    end
    m_ctrl0 = 0; m_snap_v = 0; m_pend = 0; m_disc = 0; m_snap_idx = 0; m_st_idx = 0; m_st_be = '0;
    for (int n = 0; n < 400; n++) begin
      int op, idx, lane, w;
      logic [31:0] d; logic [3:0] s; logic [63:0] word; bit hit;
      string nm;
      op = $urandom_range(0, 9); d = $urandom; s = 4'($urandom_range(0, 15));
      idx = $urandom_range(0, 7); lane = $urandom_range(0, 1);
      nm = $sformatf("r%0d op%0d", n, op);
      case (op)
        0: run(nm, 0, ra(0), s, 0, 1, {31'b0, m_ctrl0}, 0, 1, -1, -1);
        1: run(nm, 0, ra(4), s, 0, 1, {29'b0, m_disc, m_snap_v, m_pend}, 0, 1, -1, -1);
        2: begin
          d[31] = ($urandom_range(0, 3) == 0);
          run(nm, 1, ra(0), s, d, 0, 0, 0, 1, -1, -1);
          if (s[0]) m_ctrl0 = d[0];
          if (s[3] && d[31]) begin m_pend = 0; m_st_be = '0; m_snap_v = 0; end
        end
        3: begin
          run(nm, 1, ra(4), s, d, 0, 0, 0, 1, -1, -1);
          if (s[0] && d[2]) m_disc = 0;
        end
        4: begin
          w = $urandom_range(2, 63);
          run(nm, 1'($urandom_range(0, 1)), 7'(w), s, d, 0, 0, 1, 1, -1, -1);
        end
        5, 6: begin
          hit = (lane != 0) && m_snap_v && (m_snap_idx == idx);
          word = exp_mem[idx];
          run(nm, 0, ma(idx, lane), s, 0, 1, word[lane*32 +: 32], 0,
              hit ? 1 : MISS, hit ? -1 : 1, -1);
          if (!hit) begin m_snap_v = 1; m_snap_idx = idx; end
        end
        default: begin
          if (op == 7) s = 4'h0;
          if (lane == 0) begin
            run(nm, 1, ma(idx, 0), s, d, 0, 0, 0, 1, -1, -1);
            if (s != 0) begin
              if (m_pend && m_st_idx != idx) begin m_disc = 1; m_st_be = '0; end
              for (int j = 0; j < 4; j++)
                if (s[j]) begin m_st_b[j] = d[j*8 +: 8]; m_st_be[j] = 1'b1; end
              m_pend = 1; m_st_idx = idx;
            end
          end else begin
            run(nm, 1, ma(idx, 1), s, d, 0, 0, 0, 2, -1, 1);
            if (m_pend && m_st_idx != idx) begin m_disc = 1; m_st_be = '0; end
            word = exp_mem[idx];
            for (int b = 0; b < NB; b++) if (m_st_be[b]) word[b*8 +: 8] = m_st_b[b];
            for (int j = 0; j < 4; j++) if (s[j]) word[32 + j*8 +: 8] = d[j*8 +: 8];
            exp_mem[idx] = word;
            m_pend = 0; m_st_be = '0;
            if (m_snap_v && m_snap_idx == idx) m_snap_v = 0;
            chk({nm, " sram word"}, sram[idx], exp_mem[idx]);
          end
        end
      endcase
    end
    run("final status", 0, ra(4), 4'hF, 0, 1, {29'b0, m_disc, m_snap_v, m_pend}, 0, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
